mem_test_sequencer: RTL and testbench

MEM_TEST_SEQUENCER -- requirements
Module: mem_test_sequencer

---
 rtl/mem_test_pkg.sv | 28 ++
 rtl/mem_test_watchdog.sv | 27 ++
 rtl/mem_test_sequencer.sv | 146 ++++++++++++++
 tb/tb_mem_test_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_test_pkg.sv
// Shared types and default sizing for the memory test sequencer.
package mem_test_pkg;

   localparam int DEF_ADDR_WIDTH  = 25;
   localparam int DEF_DATA_WIDTH  = 16;
   localparam int DEF_LEN_WIDTH   = 16;
   localparam int DEF_ACK_TIMEOUT = 1024;

   typedef enum logic [1:0] {
      MODE_WRITE1 = 2'd0,
      MODE_READ1  = 2'd1,
      MODE_FILL   = 2'd2,
      MODE_VERIFY = 2'd3
   } mode_t;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ISSUE    = 3'd1,
      ST_WAIT_ACK = 3'd2,
      ST_NEXT     = 3'd3,
      ST_DONE     = 3'd4
   } state_t;

   function automatic logic mode_is_write(input mode_t m);
      return (m == MODE_WRITE1) || (m == MODE_FILL);
   endfunction

endpackage

// File: rtl/mem_test_watchdog.sv
// Ack-timeout counter: runs while enabled, flags expiry on the TIMEOUT-th cycle.
module mem_test_watchdog
   import mem_test_pkg::*;
#(
   parameter int TIMEOUT = DEF_ACK_TIMEOUT
) (
   input  logic sys_clk,
   input  logic sys_rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge sys_clk) begin
      if (sys_rst || clear)
         cnt <= '0;
      else if (enable && !expired)
         cnt <= cnt + CW'(1);
   end

   assign expired = enable && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_test_sequencer.sv
// Memory test sequencer: single write/read, pattern fill and verify over a word range.
// Optional first-mismatch log enabled by defining MEM_TEST_ERR_LOG_EN.
module mem_test_sequencer
   import mem_test_pkg::*;
#(
   parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int LEN_WIDTH   = DEF_LEN_WIDTH,
   parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst,
   input  logic                  start_i,
   input  logic [1:0]            mode_i,
   input  logic [ADDR_WIDTH-1:0] base_addr_i,
   input  logic [LEN_WIDTH-1:0]  len_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  timeout_o,
   output logic [DATA_WIDTH-1:0] rdata_o,
   output logic [LEN_WIDTH-1:0]  err_cnt_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_data_o,
   output logic                  mem_we_o,
   output logic                  mem_re_o,
   input  logic [DATA_WIDTH-1:0] mem_data_i,
   input  logic                  mem_ack_i,
   input  logic                  mem_busy_i
`ifdef MEM_TEST_ERR_LOG_EN
   ,
   output logic                  first_err_vld_o,
   output logic [ADDR_WIDTH-1:0] first_err_addr_o,
   output logic [DATA_WIDTH-1:0] first_err_exp_o,
   output logic [DATA_WIDTH-1:0] first_err_got_o
`endif
);

   state_t                state;
   mode_t                 mode_r;
   logic [ADDR_WIDTH-1:0] base_r;
   logic [DATA_WIDTH-1:0] wdata_r;
   logic [LEN_WIDTH-1:0]  len_r;
   logic [LEN_WIDTH-1:0]  idx_r;

   logic                  is_wr;
   logic                  issue_go;
   logic                  mismatch;
   logic                  wd_expired;
   logic [LEN_WIDTH-1:0]  word_cnt;
   logic [LEN_WIDTH-1:0]  idx_nxt;
   logic [DATA_WIDTH-1:0] pat;

   assign is_wr    = mode_is_write(mode_r);
   assign word_cnt = (mode_r == MODE_WRITE1 || mode_r == MODE_READ1) ? LEN_WIDTH'(1) : len_r;
   assign idx_nxt  = idx_r + LEN_WIDTH'(1);
   // idx is 0 for single-word commands, so the pattern doubles as WRITE1 data
   assign pat      = wdata_r + DATA_WIDTH'(idx_r);
   assign mismatch = (mode_r == MODE_VERIFY) && (mem_data_i != pat);

   // Strobe fires in the ISSUE cycle the controller is free; one cycle only since ISSUE is left
   assign issue_go   = (state == ST_ISSUE) && !mem_busy_i;
   assign mem_we_o   = issue_go && is_wr;
   assign mem_re_o   = issue_go && !is_wr;
   assign mem_addr_o = base_r + ADDR_WIDTH'(idx_r);
   assign mem_data_o = pat;

   assign busy_o = (state == ST_ISSUE) || (state == ST_WAIT_ACK) || (state == ST_NEXT);
   assign done_o = (state == ST_DONE);

   mem_test_watchdog #(.TIMEOUT(ACK_TIMEOUT)) u_wd (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .clear   (state != ST_WAIT_ACK),
      .enable  (state == ST_WAIT_ACK),
      .expired (wd_expired)
   );

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state     <= ST_IDLE;
         mode_r    <= MODE_WRITE1;
         base_r    <= '0;
         wdata_r   <= '0;
         len_r     <= '0;
         idx_r     <= '0;
         timeout_o <= 1'b0;
         rdata_o   <= '0;
         err_cnt_o <= '0;
`ifdef MEM_TEST_ERR_LOG_EN
         first_err_vld_o  <= 1'b0;
         first_err_addr_o <= '0;
         first_err_exp_o  <= '0;
         first_err_got_o  <= '0;
`endif
      end else begin
         case (state)
            ST_IDLE: if (start_i) begin
               mode_r    <= mode_t'(mode_i);
               base_r    <= base_addr_i;
               wdata_r   <= wdata_i;
               len_r     <= len_i;
               idx_r     <= '0;
               err_cnt_o <= '0;
               timeout_o <= 1'b0;
`ifdef MEM_TEST_ERR_LOG_EN
               first_err_vld_o  <= 1'b0;
               first_err_addr_o <= '0;
               first_err_exp_o  <= '0;
               first_err_got_o  <= '0;
`endif
               // Empty FILL/VERIFY completes without touching memory
               state <= (mode_i[1] && len_i == '0) ? ST_DONE : ST_ISSUE;
            end
            ST_ISSUE: if (!mem_busy_i) state <= ST_WAIT_ACK;
            ST_WAIT_ACK: begin
               if (mem_ack_i) begin
                  if (!is_wr) rdata_o <= mem_data_i;
                  if (mismatch) begin
                     if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + LEN_WIDTH'(1);
`ifdef MEM_TEST_ERR_LOG_EN
                     if (!first_err_vld_o) begin
                        first_err_vld_o  <= 1'b1;
                        first_err_addr_o <= mem_addr_o;
                        first_err_exp_o  <= pat;
                        first_err_got_o  <= mem_data_i;
                     end
`endif
                  end
                  state <= ST_NEXT;
               end else if (wd_expired) begin
                  timeout_o <= 1'b1;
                  state     <= ST_DONE;
               end
            end
            ST_NEXT: begin
               idx_r <= idx_nxt;
               state <= (idx_nxt == word_cnt) ? ST_DONE : ST_ISSUE;
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_test_sequencer.sv
// Directed bench for mem_test_sequencer: scoreboarded requests against a small memory model.
module tb_mem_test_sequencer;

   typedef struct packed {
      logic        we;
      logic [24:0] addr;
      logic [15:0] data;
   } req_t;

   logic        sys_clk = 1'b0;
   logic        sys_rst;
   logic        start_i;
   logic [1:0]  mode_i;
   logic [24:0] base_addr_i;
   logic [15:0] len_i;
   logic [15:0] wdata_i;
   logic        busy_o, done_o, timeout_o;
   logic [15:0] rdata_o;
   logic [15:0] err_cnt_o;
   logic [24:0] mem_addr_o;
   logic [15:0] mem_data_o;
   logic        mem_we_o, mem_re_o;
   logic [15:0] mem_data_i;
   logic        mem_ack_i;
   logic        mem_busy_i;
`ifdef MEM_TEST_ERR_LOG_EN
   logic        first_err_vld_o;
   logic [24:0] first_err_addr_o;
   logic [15:0] first_err_exp_o;
   logic [15:0] first_err_got_o;
`endif

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int strobe_cnt = 0;
   int unexp_cnt  = 0;
   int last_strobe_cyc = 0;

   req_t        sb[$];
   req_t        mon_r;
   logic [15:0] mem [logic [24:0]];
   logic        mon_en = 1'b0;
   logic        pend = 1'b0;
   int          pend_cnt = 0;
   int          ack_lat = 3;
   logic        ack_en = 1'b1;
   logic [24:0] paddr = '0;
   logic        corrupt_en = 1'b0;
   logic [24:0] corrupt_addr = '0;

   mem_test_sequencer #(.ACK_TIMEOUT(16)) dut (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .start_i     (start_i),
      .mode_i      (mode_i),
      .base_addr_i (base_addr_i),
      .len_i       (len_i),
      .wdata_i     (wdata_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .timeout_o   (timeout_o),
      .rdata_o     (rdata_o),
      .err_cnt_o   (err_cnt_o),
      .mem_addr_o  (mem_addr_o),
      .mem_data_o  (mem_data_o),
      .mem_we_o    (mem_we_o),
      .mem_re_o    (mem_re_o),
      .mem_data_i  (mem_data_i),
      .mem_ack_i   (mem_ack_i),
      .mem_busy_i  (mem_busy_i)
`ifdef MEM_TEST_ERR_LOG_EN
      ,
      .first_err_vld_o  (first_err_vld_o),
      .first_err_addr_o (first_err_addr_o),
      .first_err_exp_o  (first_err_exp_o),
      .first_err_got_o  (first_err_got_o)
`endif
   );

   always #5 sys_clk = ~sys_clk;
   always @(posedge sys_clk) cyc++;

   initial begin
      #400000;
      $display("FAIL global_timeout sim did not finish");
      $fatal(1, "bench timeout");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] rd_val(input logic [24:0] a);
      logic [15:0] v;
      v = mem.exists(a) ? mem[a] : 16'h0000;
      if (corrupt_en && a == corrupt_addr) v = v ^ 16'h0040;
      return v;
   endfunction

   // Request monitor: scoreboard check, memory update, ack scheduling
   always @(negedge sys_clk) begin
      if (mon_en && (mem_we_o || mem_re_o)) begin
         strobe_cnt++;
         last_strobe_cyc = cyc;
         chk("strobe_excl", {31'b0, mem_we_o & mem_re_o}, 32'd0);
         if (sb.size() == 0) unexp_cnt++;
         else begin
            mon_r = sb.pop_front();
            chk("req_we", {31'b0, mem_we_o}, {31'b0, mon_r.we});
            chk("req_addr", {7'b0, mem_addr_o}, {7'b0, mon_r.addr});
            if (mon_r.we) chk("req_data", {16'b0, mem_data_o}, {16'b0, mon_r.data});
         end
         if (mem_we_o) mem[mem_addr_o] = mem_data_o;
         paddr    = mem_addr_o;
         pend     = ack_en;
         pend_cnt = ack_lat;
      end
   end

   // Ack responder: ack_lat cycles after the strobe cycle
   initial begin
      mem_ack_i  = 1'b0;
      mem_data_i = '0;
      forever begin
         @(posedge sys_clk); #1;
         mem_ack_i = 1'b0;
         if (pend) begin
            if (pend_cnt <= 1) begin
               mem_ack_i  = 1'b1;
               mem_data_i = rd_val(paddr);
               pend       = 1'b0;
            end else pend_cnt--;
         end
      end
   end

   task automatic exp_cmd(input logic [1:0] m, input logic [24:0] b, input logic [15:0] l,
                          input logic [15:0] w);
      int n;
      req_t r;
      n = (m < 2) ? 1 : int'(l);
      for (int i = 0; i < n; i++) begin
         r.we   = (m == 2'd0) || (m == 2'd2);
         r.addr = b + 25'(i);
         r.data = w + 16'(i);
         sb.push_back(r);
      end
   endtask

   function automatic int exp_errs(input logic [24:0] b, input logic [15:0] l, input logic [15:0] w);
      int e = 0;
      for (int i = 0; i < int'(l); i++)
         if (rd_val(b + 25'(i)) != w + 16'(i)) e++;
      return e;
   endfunction

   // Drive one start strobe, scramble inputs afterwards, return at the next negedge
   task automatic start_cmd(input logic [1:0] m, input logic [24:0] b, input logic [15:0] l,
                            input logic [15:0] w);
      exp_cmd(m, b, l, w);
      @(posedge sys_clk); #1;
      start_i = 1'b1; mode_i = m; base_addr_i = b; len_i = l; wdata_i = w;
      @(posedge sys_clk); #1;
      start_i = 1'b0; mode_i = m ^ 2'b01; base_addr_i = ~b; len_i = ~l; wdata_i = ~w;
      @(negedge sys_clk);
   endtask

   task automatic wait_done(input int budget, output int dcyc);
      int n = 0;
      while (!done_o && n < budget) begin
         @(negedge sys_clk);
         n++;
      end
      chk("done_seen", {31'b0, done_o}, 32'd1);
      dcyc = cyc;
      chk("busy_in_done", {31'b0, busy_o}, 32'd0);
      @(negedge sys_clk);
      chk("done_1cyc", {31'b0, done_o}, 32'd0);
      chk("sb_empty", sb.size(), 32'd0);
      chk("no_unexpected_req", unexp_cnt, 32'd0);
   endtask

   initial begin
      int dcyc, s0, n;
      sys_rst = 1'b1; start_i = 1'b0; mode_i = '0; base_addr_i = '0; len_i = '0;
      wdata_i = '0; mem_busy_i = 1'b0;
      repeat (3) @(posedge sys_clk);
      @(negedge sys_clk);
      chk("rst_busy", {31'b0, busy_o}, 32'd0);
      chk("rst_done", {31'b0, done_o}, 32'd0);
      chk("rst_timeout", {31'b0, timeout_o}, 32'd0);
      chk("rst_rdata", {16'b0, rdata_o}, 32'd0);
      chk("rst_err", {16'b0, err_cnt_o}, 32'd0);
      chk("rst_strobes", {30'b0, mem_we_o, mem_re_o}, 32'd0);
      chk("rst_addr", {7'b0, mem_addr_o}, 32'd0);
      chk("rst_data", {16'b0, mem_data_o}, 32'd0);
      @(posedge sys_clk); #1;
      sys_rst = 1'b0;
      mon_en  = 1'b1;

      // WRITE1, ack 3 cycles after strobe
      s0 = strobe_cnt;
      start_cmd(2'd0, 25'h0010, 16'd0, 16'h1234);
      chk("w1_busy_next", {31'b0, busy_o}, 32'd1);
      wait_done(100, dcyc);
      chk("w1_one_strobe", strobe_cnt - s0, 32'd1);

      // READ1 back
      start_cmd(2'd1, 25'h0010, 16'd0, 16'h0000);
      wait_done(100, dcyc);
      chk("r1_rdata", {16'b0, rdata_o}, 32'h1234);

      // FILL across the address and data wrap; a start while busy is ignored
      ack_lat = 1;
      start_cmd(2'd2, 25'h1FFFFFE, 16'd4, 16'hFFFE);
      @(posedge sys_clk); #1;
      start_i = 1'b1; mode_i = 2'd0; base_addr_i = 25'h7777; wdata_i = 16'hDEAD;
      @(posedge sys_clk); #1;
      start_i = 1'b0;
      @(negedge sys_clk);
      wait_done(200, dcyc);

      // VERIFY the wrapped fill: clean
      start_cmd(2'd3, 25'h1FFFFFE, 16'd4, 16'hFFFE);
      wait_done(200, dcyc);
      chk("v_wrap_err", {16'b0, err_cnt_o}, 32'd0);

      // FILL 8 then VERIFY with index 5 corrupted
      ack_lat = 2;
      start_cmd(2'd2, 25'h0100, 16'd8, 16'hA000);
      wait_done(300, dcyc);
      corrupt_en = 1'b1; corrupt_addr = 25'h0105;
      n = exp_errs(25'h0100, 16'd8, 16'hA000);
      start_cmd(2'd3, 25'h0100, 16'd8, 16'hA000);
      wait_done(300, dcyc);
      chk("v_corrupt_err", {16'b0, err_cnt_o}, n);
      chk("v_corrupt_rdata", {16'b0, rdata_o}, 32'hA007);
`ifdef MEM_TEST_ERR_LOG_EN
      chk("log_vld", {31'b0, first_err_vld_o}, 32'd1);
      chk("log_addr", {7'b0, first_err_addr_o}, 32'h0105);
      chk("log_exp", {16'b0, first_err_exp_o}, 32'hA005);
      chk("log_got", {16'b0, first_err_got_o}, 32'hA045);
`endif
      corrupt_en = 1'b0;

      // Empty FILL: straight to DONE, no strobe, err count cleared
      s0 = strobe_cnt;
      start_cmd(2'd2, 25'h0400, 16'd0, 16'h0000);
      chk("len0_done_now", {31'b0, done_o}, 32'd1);
      chk("len0_err_clr", {16'b0, err_cnt_o}, 32'd0);
`ifdef MEM_TEST_ERR_LOG_EN
      chk("log_clr", {31'b0, first_err_vld_o}, 32'd0);
`endif
      wait_done(10, dcyc);
      chk("len0_no_strobe", strobe_cnt - s0, 32'd0);

      // Controller busy for 10 ISSUE cycles
      ack_lat = 3;
      mem_busy_i = 1'b1;
      s0 = strobe_cnt;
      start_cmd(2'd0, 25'h0020, 16'd0, 16'h5555);
      for (int k = 0; k < 10; k++) begin
         chk("mbusy_no_strobe", {30'b0, mem_we_o, mem_re_o}, 32'd0);
         chk("mbusy_busy", {31'b0, busy_o}, 32'd1);
         if (k < 9) @(negedge sys_clk);
      end
      @(posedge sys_clk); #1;
      mem_busy_i = 1'b0;
      @(negedge sys_clk);
      wait_done(100, dcyc);
      chk("mbusy_one_strobe", strobe_cnt - s0, 32'd1);

      // READ1 with no ack: timeout
      ack_en = 1'b0;
      start_cmd(2'd1, 25'h0030, 16'd0, 16'h0000);
      wait_done(100, dcyc);
      chk("to_latency", dcyc - last_strobe_cyc, 32'd17);
      chk("to_flag", {31'b0, timeout_o}, 32'd1);
      ack_en = 1'b1;
      start_cmd(2'd1, 25'h0020, 16'd0, 16'h0000);
      chk("to_flag_clr", {31'b0, timeout_o}, 32'd0);
      wait_done(100, dcyc);
      chk("r1b_rdata", {16'b0, rdata_o}, 32'h5555);

      // Reset in the middle of a FILL at i=3
      ack_lat = 2;
      s0 = strobe_cnt;
      start_cmd(2'd2, 25'h0200, 16'd8, 16'h0000);
      n = 0;
      while (strobe_cnt < s0 + 4 && n < 200) begin
         @(posedge sys_clk); #1;
         n++;
      end
      chk("rst_mid_reach_i3", strobe_cnt - s0, 32'd4);
      sys_rst = 1'b1;
      pend = 1'b0;
      sb.delete();
      @(posedge sys_clk); #1;
      @(negedge sys_clk);
      chk("rst_mid_busy", {31'b0, busy_o}, 32'd0);
      chk("rst_mid_strobes", {30'b0, mem_we_o, mem_re_o}, 32'd0);
      @(posedge sys_clk); #1;
      sys_rst = 1'b0;
      chk("rst_mid_no_more", strobe_cnt - s0, 32'd4);
      s0 = strobe_cnt;
      start_cmd(2'd0, 25'h0300, 16'd0, 16'hBEEF);
      wait_done(100, dcyc);
      chk("post_rst_strobe", strobe_cnt - s0, 32'd1);
      chk("post_rst_mem", {16'b0, rd_val(25'h0300)}, 32'hBEEF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
